// File: rtl/pixel_channel_fifo_if.sv
// Channel bus between the rasterizer write port, the FIFO and contention_tree.
// slave = FIFO side; master = the agents driving writes and requests.
interface pixel_channel_fifo_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LENGTH      = 8
);
    logic                   wr_en;
    logic [PIXEL_WIDTH-1:0] pix_in;
    logic                   full;
    logic                   almost_full;
    logic                   overflow;
    logic [LENGTH-1:0]      fill;
    logic                   req;
    logic                   ack;
    logic [PIXEL_WIDTH-1:0] pix_out;

    modport slave (
        input  wr_en, pix_in, req,
        output full, almost_full, overflow, fill, ack, pix_out
    );

    modport master (
        output wr_en, pix_in, req,
        input  full, almost_full, overflow, fill, ack, pix_out
    );
endinterface

// File: rtl/pixel_channel_fifo.sv
// Per-channel pixel FIFO: strobe writes in, one pixel out per four-phase req/ack
// handshake, occupancy exported so contention_tree can favour the fullest channel.
module pixel_channel_fifo #(
    parameter int PIXEL_WIDTH = 8,
    parameter int LENGTH      = 8,
    parameter int DEPTH       = 16,
    parameter int AF_THRESH   = 12
) (
    input  logic                clk,
    input  logic                rst,
    pixel_channel_fifo_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ACK} state_e;
    typedef logic [PTR_W-1:0] ptr_t;

    logic [PIXEL_WIDTH-1:0] mem_q [DEPTH];
    ptr_t                   wr_ptr_q, wr_ptr_d;
    ptr_t                   rd_ptr_q, rd_ptr_d;
    logic [LENGTH-1:0]      count_q, count_d;
    state_e                 state_q, state_d;
    logic [PIXEL_WIDTH-1:0] pix_out_q, pix_out_d;
    logic                   overflow_q, overflow_d;
    logic                   push, pop, is_full, is_empty;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        is_full    = (count_q == LENGTH'(DEPTH));
        is_empty   = (count_q == '0);
        push       = bus.wr_en && !is_full;
        pop        = (state_q == IDLE) && bus.req && !is_empty;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        state_d    = state_q;
        pix_out_d  = pix_out_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        // A pop in the same cycle never frees room for a write seen as full.
        if (bus.wr_en && is_full) overflow_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    pix_out_d = mem_q[rd_ptr_q];
                    rd_ptr_d  = ptr_inc(rd_ptr_q);
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (!bus.req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        count_d = count_q + LENGTH'(push) - LENGTH'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            pix_out_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            pix_out_q  <= pix_out_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.pix_in;
    end

    assign bus.full        = is_full;
    assign bus.almost_full = (count_q >= LENGTH'(AF_THRESH));
    assign bus.overflow    = overflow_q;
    assign bus.fill        = count_q;
    assign bus.ack         = (state_q == ACK);
    assign bus.pix_out     = pix_out_q;
endmodule

// File: tb/tb_pixel_channel_fifo.sv
// Directed bench for pixel_channel_fifo: queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pixel_channel_fifo;
    localparam int PW = 8, LW = 8, DEPTH = 16, AFT = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_channel_fifo_if #(.PIXEL_WIDTH(PW), .LENGTH(LW)) bus ();

    pixel_channel_fifo #(.PIXEL_WIDTH(PW), .LENGTH(LW), .DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue plus the handshake rule "one pop per req high phase".
    logic [PW-1:0] mq [$];
    logic          m_ack = 1'b0;
    logic [PW-1:0] m_pix = '0;
    logic          m_ovf = 1'b0;
    bit            check_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ack = 1'b0;
            m_pix = '0;
            m_ovf = 1'b0;
            check_en = 1'b1;
        end else begin
            bit do_pop, do_push;
            do_pop  = !m_ack && bus.req && (mq.size() > 0);
            do_push = bus.wr_en && (mq.size() < DEPTH);
            if (bus.wr_en && mq.size() == DEPTH) m_ovf = 1'b1;
            if (do_pop) begin
                m_pix = mq.pop_front();
                m_ack = 1'b1;
            end else if (m_ack && !bus.req) begin
                m_ack = 1'b0;
            end
            if (do_push) mq.push_back(bus.pix_in);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_ack",      32'(bus.ack),         32'(m_ack));
            chk("cmp_pix_out",  32'(bus.pix_out),     32'(m_pix));
            chk("cmp_fill",     32'(bus.fill),        32'(mq.size()));
            chk("cmp_full",     32'(bus.full),        32'(mq.size() == DEPTH));
            chk("cmp_afull",    32'(bus.almost_full), 32'(mq.size() >= AFT));
            chk("cmp_overflow", 32'(bus.overflow),    32'(m_ovf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [PW-1:0] s1 [4];
        s1[0] = 8'hE2; s1[1] = 8'hA5; s1[2] = 8'h78; s1[3] = 8'h4B;
        bus.wr_en = 1'b0;
        bus.pix_in = '0;
        bus.req = 1'b0;

        // 1: reset, then four writes
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_fill", 32'(bus.fill), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_pix", 32'(bus.pix_out), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_af", 32'(bus.almost_full), 0);
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1;
            bus.pix_in = s1[i];
            step();
            chk("s1_fill", 32'(bus.fill), 32'(i + 1));
            chk("s1_ack", 32'(bus.ack), 0);
        end
        bus.wr_en = 1'b0;

        // 2: four handshakes, req high 3 cycles then low 1
        for (int i = 0; i < 4; i++) begin
            bus.req = 1'b1;
            step();
            chk("s2_ack_rise", 32'(bus.ack), 1);
            chk("s2_pix", 32'(bus.pix_out), 32'(s1[i]));
            chk("s2_fill", 32'(bus.fill), 32'(3 - i));
            step();
            step();
            chk("s2_ack_hold", 32'(bus.ack), 1);
            chk("s2_fill_hold", 32'(bus.fill), 32'(3 - i));
            bus.req = 1'b0;
            step();
            chk("s2_ack_fall", 32'(bus.ack), 0);
        end

        // 3: 17 writes, last one overflows; then drain 16
        for (int i = 0; i < 17; i++) begin
            bus.wr_en = 1'b1;
            bus.pix_in = PW'(i);
            step();
            chk("s3_fill", 32'(bus.fill), (i < 16) ? 32'(i + 1) : 32'd16);
            chk("s3_af", 32'(bus.almost_full), 32'(i + 1 >= 12));
            chk("s3_full", 32'(bus.full), 32'(i + 1 >= 16));
            chk("s3_ovf", 32'(bus.overflow), 32'(i == 16));
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.req = 1'b1;
            step();
            chk("s3_drain_pix", 32'(bus.pix_out), 32'(i));
            bus.req = 1'b0;
            step();
        end
        chk("s3_ovf_sticky", 32'(bus.overflow), 1);
        chk("s3_empty", 32'(bus.fill), 0);

        // 4: req waiting on empty FIFO, write arrives
        bus.req = 1'b1;
        step();
        chk("s4_no_ack", 32'(bus.ack), 0);
        bus.wr_en = 1'b1;
        bus.pix_in = 8'h9D;
        step();
        chk("s4_fill_k", 32'(bus.fill), 1);
        chk("s4_ack_k", 32'(bus.ack), 0);
        bus.wr_en = 1'b0;
        step();
        chk("s4_ack_k1", 32'(bus.ack), 1);
        chk("s4_pix_k1", 32'(bus.pix_out), 32'h9D);
        chk("s4_fill_k1", 32'(bus.fill), 0);
        bus.req = 1'b0;
        step();

        // 5: 8 resident, then push on every pop across several pointer wraps
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1;
            bus.pix_in = PW'(i);
            step();
        end
        for (int i = 0; i < 40; i++) begin
            bus.wr_en = 1'b1;
            bus.pix_in = PW'(i + 8);
            bus.req = 1'b1;
            step();
            chk("s5_fill", 32'(bus.fill), 8);
            chk("s5_pix", 32'(bus.pix_out), 32'(i));
            bus.wr_en = 1'b0;
            bus.req = 1'b0;
            step();
            chk("s5_fill_idle", 32'(bus.fill), 8);
        end

        // 6: reset in the middle of a handshake
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1;
            bus.pix_in = PW'(8'hC0 + i);
            step();
        end
        bus.wr_en = 1'b0;
        bus.req = 1'b1;
        step();
        chk("s6_ack_pre", 32'(bus.ack), 1);
        chk("s6_pix_pre", 32'(bus.pix_out), 32'hC0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s6_ack", 32'(bus.ack), 0);
        chk("s6_fill", 32'(bus.fill), 0);
        chk("s6_pix", 32'(bus.pix_out), 0);
        chk("s6_ovf", 32'(bus.overflow), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s6_no_ack", 32'(bus.ack), 0);
        end
        bus.wr_en = 1'b1;
        bus.pix_in = 8'h3C;
        step();
        bus.wr_en = 1'b0;
        step();
        chk("s6_ack_new", 32'(bus.ack), 1);
        chk("s6_pix_new", 32'(bus.pix_out), 32'h3C);
        bus.req = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pixel_channel_fifo.md
Name: pixel_channel_fifo

Overview:
Per-channel pixel buffer sitting directly upstream of contention_tree; four instances feed pix_in_1..4, fill_1..4 and the req/ack pairs.
- Accepts pixels from the rasterizer side on a simple write strobe.
- Reports its occupancy on fill so the tree can prioritise the fullest channel.
- Releases exactly one pixel per four-phase req/ack handshake initiated by the tree.

Parameters:
PIXEL_WIDTH, 8, width of one pixel word
LENGTH, 8, width of fill output (occupancy count)
DEPTH, 16, number of storage entries; must satisfy 2 <= DEPTH <= 2**LENGTH-1
AF_THRESH, 12, occupancy at/above which almost_full asserts; 1 <= AF_THRESH <= DEPTH

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe from rasterizer side
pix_in  in  PIXEL_WIDTH  pixel to write when wr_en=1
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
overflow  out  1  sticky: a write was dropped because FIFO was full
fill  out  LENGTH  current occupancy, zero-extended count, to contention_tree fill_n
req  in  1  pixel request from contention_tree (level, four-phase)
ack  out  1  pixel valid / request acknowledged, to contention_tree
pix_out  out  PIXEL_WIDTH  popped pixel, to contention_tree pix_in_n

Behaviour:
- Reset (rst=1 at rising edge): wr_ptr=rd_ptr=count=0, state=IDLE, ack=0, pix_out=0, overflow=0; full=0, fill=0; almost_full=0 (AF_THRESH>=1). Stored contents discarded. Reset wins over every simultaneous event, including mid-handshake: ack drops after that edge.
- Storage: circular buffer of DEPTH entries. Pointers wrap from DEPTH-1 to 0 (DEPTH need not be a power of two). Occupancy is tracked in a separate count register.
- Write: accepted iff wr_en=1 and count<DEPTH, using the count registered at the start of the cycle. Accepted: mem[wr_ptr]<=pix_in, wr_ptr advances. Rejected (wr_en=1, count==DEPTH): data dropped, overflow<=1, held until reset. A pop in the same cycle does not rescue a write when full.
- full, almost_full, fill: combinational from the count register. A write accepted at edge k is reflected in fill after edge k.
- Read FSM, two states:
  - IDLE, ack=0. If req=1 and count>0 at an edge: pix_out<=mem[rd_ptr], rd_ptr advances, ack<=1, go to ACK. If req=1 and count==0: stay IDLE and wait; the pop occurs on the first edge with count>0.
  - ACK, ack=1, pix_out held stable. Stay while req=1. When req=0 at an edge: ack<=0, go to IDLE. pix_out keeps its last value.
  - Exactly one pop per handshake. A new pop needs req to be seen low then high again.
- Latency: req rising sampled at edge k with data present -> ack=1 and pix_out valid after edge k (1 cycle).
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Empty FIFO with wr_en and req in the same cycle: no pop that cycle (count was 0); pop at the next edge.
- Count arithmetic: count_next = count + push - pop, push/pop in {0,1}. Never underflows; never exceeds DEPTH.

Test Plan:
1. Reset, then write E2,A5,78,4B on 4 consecutive cycles, req=0 -> fill=0,1,2,3,4 after successive edges; ack=0; full=0; almost_full=0.
2. From scenario 1: req=1 held 3 cycles, then req=0 for 1 cycle, repeated 4 times -> each handshake gives ack=1 one cycle after req rises; pix_out=E2,A5,78,4B in order; fill decrements 4->0; ack=0 one cycle after each req falls.
3. Fill FIFO with 17 writes 0x00..0x10 (DEPTH=16) -> almost_full=1 from fill=12; full=1 at fill=16; 17th write sets overflow=1; fill stays 16. Drain all 16 -> pix_out 0x00..0x0F; overflow still 1.
4. Empty FIFO, req=1 held, write 0x9D at edge k -> fill=1 after k; ack=1 and pix_out=9D after edge k+1; fill=0 after edge k+1.
5. Wrap/concurrent access: keep 8 entries resident, then push and pop simultaneously for 40 cycles with incrementing data -> fill constant 8; pix_out sequence strictly incrementing with no gaps or duplicates across pointer wrap.
6. Mid-handshake reset: 3 entries, req=1, ack=1, assert rst one cycle -> after that edge ack=0, fill=0, pix_out=0, overflow=0; holding req=1 afterwards gives no ack until a new write.
